// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the run controller.
package run_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_e;

  localparam int RESET_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 16;
  localparam int MAX_CYCLES_DEF   = 4096;
endpackage

// File: rtl/run_cycle_ctr.sv
// Run-cycle counter: synchronous clear, enable, saturates at all-ones instead of wrapping.
module run_cycle_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  count <= '0;
    else if (clr)                count <= '0;
    else if (en && (count != '1)) count <= count + 1'b1;
  end
endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, runs it until done/abort/watchdog, then waits for req low.
// Optional watchdog is compiled in with `define RUN_CTRL_WATCHDOG_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MAX_CYCLES   = MAX_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             abort,
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             aborted,
  output logic [CNT_W-1:0] cycle_count
);
  run_state_e state;
  logic [7:0] hold_cnt;
  logic       aborted_q;
  logic       start;

  assign start = (state == ST_IDLE) && req;

`ifdef RUN_CTRL_WATCHDOG_EN
  logic timeout_q;
  logic wd_hit;
  // Count shows completed RUN cycles, so MAX_CYCLES-1 means this is the last allowed one.
  assign wd_hit  = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      aborted_q <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          state     <= ST_HOLD;
          hold_cnt  <= 8'(RESET_CYCLES - 1);
          aborted_q <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
          timeout_q <= 1'b0;
`endif
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state <= ST_RUN;
          else                hold_cnt <= hold_cnt - 8'd1;
        end
        ST_RUN: begin
          if (core_done) state <= ST_DONE;
          else if (abort) begin
            state     <= ST_DONE;
            aborted_q <= 1'b1;
          end
`ifdef RUN_CTRL_WATCHDOG_EN
          else if (wd_hit) begin
            state     <= ST_DONE;
            timeout_q <= 1'b1;
          end
`endif
        end
        ST_DONE: if (!req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Core state is left intact in DONE so it can be inspected; reset only while idle/holding.
  assign core_reset = (state == ST_IDLE) || (state == ST_HOLD);
  assign core_en    = (state == ST_RUN);
  assign busy       = (state == ST_HOLD) || (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign aborted    = aborted_q;

  run_cycle_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (state == ST_RUN),
    .count (cycle_count)
  );
endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus randomized traffic against a phase/count model.
module tb_run_ctrl;
  localparam int RC  = 2;
  localparam int CW  = 4;
  localparam int MC  = 8;
  localparam int SAT = (1 << CW) - 1;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int PI = 0, PH = 1, PR = 2, PD = 3;

  logic          clk = 1'b0;
  logic          reset, req, abort, core_done;
  logic          core_reset, core_en, busy, done, timeout, aborted;
  logic [CW-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: current phase, HOLD cycles spent, RUN cycles executed (unbounded), end flags.
  int m_ph, m_hold, m_runs;
  bit m_to, m_ab;

  run_ctrl #(.RESET_CYCLES(RC), .CNT_W(CW), .MAX_CYCLES(MC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .abort       (abort),
    .core_done   (core_done),
    .core_reset  (core_reset),
    .core_en     (core_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .aborted     (aborted),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = PI; m_hold = 0; m_runs = 0; m_to = 1'b0; m_ab = 1'b0;
  endfunction

  function automatic void model_step();
    case (m_ph)
      PI: if (req) begin
        m_ph = PH; m_hold = 0; m_runs = 0; m_to = 1'b0; m_ab = 1'b0;
      end
      PH: begin
        m_hold++;
        if (m_hold == RC) m_ph = PR;
      end
      PR: begin
        m_runs++;
        if (core_done) m_ph = PD;
        else if (abort) begin m_ph = PD; m_ab = 1'b1; end
        else if (WD && m_runs == MC) begin m_ph = PD; m_to = 1'b1; end
      end
      default: if (!req) m_ph = PI;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("core_reset", int'(core_reset), int'(m_ph == PI || m_ph == PH));
      check("core_en",    int'(core_en),    int'(m_ph == PR));
      check("busy",       int'(busy),       int'(m_ph == PH || m_ph == PR));
      check("done",       int'(done),       int'(m_ph == PD));
      check("timeout",    int'(timeout),    int'(m_to));
      check("aborted",    int'(aborted),    int'(m_ab));
      check("cycle_count", int'(cycle_count), (m_runs > SAT) ? SAT : m_runs);
    end
  end

  initial begin
    reset = 1'b0; req = 1'b0; abort = 1'b0; core_done = 1'b0;
    model_reset();
    #13;
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_core_en", int'(core_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(cycle_count), 0);
    chk_en = 1'b1;

    // Basic run: two HOLD cycles, core_done on the 10th RUN cycle.
    req = 1'b1; reset = 1'b1;
    tick(); check("c0_core_reset", int'(core_reset), 1);
    tick(); check("c1_core_reset", int'(core_reset), 1);
            check("c1_core_en", int'(core_en), 0);
    tick(); check("c2_core_en", int'(core_en), 1);
            check("c2_core_reset", int'(core_reset), 0);
    repeat (9) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("run10_done", int'(done), 1);
    check("run10_count", int'(cycle_count), 10);
    check("run10_timeout", int'(timeout), 0);

    // Four-phase handshake: DONE persists while req stays high.
    repeat (5) tick();
    check("hs_done_held", int'(done), 1);
    check("hs_busy", int'(busy), 0);
    req = 1'b0; tick();
    check("hs_done_fall", int'(done), 0);
    req = 1'b1; tick();
    check("hs_count_clr", int'(cycle_count), 0);
    check("hs_busy_hold", int'(busy), 1);

    // core_done beats abort on RUN cycle 3.
    repeat (4) tick();
    check("pri_count_pre", int'(cycle_count), 2);
    core_done = 1'b1; abort = 1'b1; tick(); core_done = 1'b0; abort = 1'b0;
    check("pri_done", int'(done), 1);
    check("pri_aborted", int'(aborted), 0);
    check("pri_count", int'(cycle_count), 3);
    req = 1'b0; tick();

    // Abort ignored in IDLE/HOLD, honoured on the first RUN cycle.
    req = 1'b1; abort = 1'b1;
    tick(); tick(); tick();
    check("ab_run", int'(core_en), 1);
    tick(); abort = 1'b0;
    check("ab_aborted", int'(aborted), 1);
    check("ab_count", int'(cycle_count), 1);
    req = 1'b0; tick();

    // Watchdog limit / saturation.
    req = 1'b1;
    repeat (11) tick();
`ifdef RUN_CTRL_WATCHDOG_EN
    check("wd_done", int'(done), 1);
    check("wd_timeout", int'(timeout), 1);
    check("wd_count", int'(cycle_count), 8);
`else
    check("nowd_busy", int'(busy), 1);
    check("nowd_timeout", int'(timeout), 0);
    check("nowd_count", int'(cycle_count), 8);
    repeat (12) tick();
    check("sat_count", int'(cycle_count), 15);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("sat_done", int'(done), 1);
    check("sat_final", int'(cycle_count), 15);
`endif
    req = 1'b0; tick();

    // Asynchronous reset between edges in RUN, then restart with req already high.
    req = 1'b1;
    repeat (5) tick();
    #3; reset = 1'b0; model_reset(); #1;
    check("ar_core_reset", int'(core_reset), 1);
    check("ar_core_en", int'(core_en), 0);
    check("ar_count", int'(cycle_count), 0);
    check("ar_busy", int'(busy), 0);
    #2; reset = 1'b1;
    tick();
    check("ar_restart", int'(busy), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = ~req;
      abort     = ($urandom_range(0, 15) == 0);
      core_done = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0; model_reset(); #2; reset = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
